// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: programmable length, inter-frame gap, port fields and
// payload mode, with packet quota, back-pressure support and transmit statistics.
module axis_pkt_gen #(
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_LEN_WIDTH          = 16,
    parameter int C_IFG_WIDTH          = 16,
    parameter int C_CNT_WIDTH          = 32
) (
    input  logic                                axi_aclk,
    input  logic                                axi_areset,
    input  logic                                cfg_enable,
    input  logic [C_LEN_WIDTH-1:0]              cfg_pkt_len,
    input  logic [C_IFG_WIDTH-1:0]              cfg_ifg,
    input  logic [C_CNT_WIDTH-1:0]              cfg_num_pkts,
    input  logic                                cfg_mode,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]      cfg_pattern,
    input  logic [7:0]                          cfg_src_port,
    input  logic [7:0]                          cfg_dst_port,
    input  logic                                stat_clear,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,
    output logic                                busy,
    output logic                                done,
    output logic [C_CNT_WIDTH-1:0]              stat_tx_pkts,
    output logic [C_CNT_WIDTH-1:0]              stat_tx_words
);

    localparam int DW = C_M_AXIS_DATA_WIDTH;
    localparam int UW = C_M_AXIS_TUSER_WIDTH;
    localparam int LW = C_LEN_WIDTH;
    localparam int IW = C_IFG_WIDTH;
    localparam int CW = C_CNT_WIDTH;
    localparam int SW = DW / 8;
    localparam int BW = $clog2(SW);
    localparam int HW = DW / 2;

    localparam logic [LW-1:0] LEN_ONE = LW'(1'b1);
    localparam logic [LW-1:0] LEN_DEF = LW'(7'd64);
    localparam logic [IW-1:0] IFG_ONE = IW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [DW-1:0] beat_data(input logic          mode,
                                                input logic [DW-1:0] pattern,
                                                input logic [CW-1:0] seq,
                                                input logic [LW-1:0] idx);
        logic [DW-1:0] d;
        if (mode) begin
            d = {HW'(seq), HW'(idx)};
        end else begin
            d = pattern;
        end
        return d;
    endfunction

    // Only the final beat can be partial; rem is the byte count modulo the bus width.
    function automatic logic [SW-1:0] beat_strb(input logic last, input logic [BW-1:0] rem);
        logic [SW-1:0] s;
        s = {SW{1'b1}};
        if (last && (rem != {BW{1'b0}})) begin
            for (int i = 0; i < SW; i++) begin
                s[i] = (i < int'(rem));
            end
        end else begin
            s = {SW{1'b1}};
        end
        return s;
    endfunction

    function automatic logic [UW-1:0] beat_user(input logic          first,
                                                input logic [LW-1:0] len,
                                                input logic [7:0]    src,
                                                input logic [7:0]    dst);
        logic [UW-1:0] u;
        u = {UW{1'b0}};
        if (first) begin
            u[31:0] = {dst, src, 16'(len)};
        end else begin
            u = {UW{1'b0}};
        end
        return u;
    endfunction

    state_t         state_q, state_d;
    logic [LW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  gap_q, gap_d;
    logic [CW-1:0]  quota_cnt_q, quota_cnt_d;

    logic [LW-1:0]  len_q;
    logic [IW-1:0]  ifg_q;
    logic [CW-1:0]  quota_q;
    logic           mode_q;
    logic [DW-1:0]  pattern_q;
    logic [7:0]     src_q, dst_q;
    logic [CW-1:0]  seq_q;

    logic [DW-1:0]  tdata_q;
    logic [SW-1:0]  tstrb_q;
    logic [UW-1:0]  tuser_q;
    logic           tvalid_q, tlast_q;
    logic           busy_q, done_q;
    logic [CW-1:0]  stat_pkts_q, stat_pkts_d;
    logic [CW-1:0]  stat_words_q, stat_words_d;

    logic           hs_s, last_hs_s;
    logic           start_pkt_s, next_beat_s, drop_valid_s;
    logic [CW-1:0]  quota_inc_s;
    logic           quota_hit_s;
    logic [LW-1:0]  eff_len_s;

    logic [LW-1:0]  b_len_s, b_idx_s, b_last_idx_s;
    logic           b_mode_s, b_last_s;
    logic [DW-1:0]  b_pattern_s;
    logic [7:0]     b_src_s, b_dst_s;
    logic [CW-1:0]  b_seq_s;

    assign hs_s        = tvalid_q & m_axis_tready;
    assign last_hs_s   = hs_s & tlast_q;
    assign eff_len_s   = (cfg_pkt_len == {LW{1'b0}}) ? LEN_DEF : cfg_pkt_len;
    assign quota_inc_s = quota_cnt_q + CNT_ONE;
    assign quota_hit_s = (quota_q != {CW{1'b0}}) && (quota_inc_s == quota_q);

    // Next-state logic; a packet start always samples the live configuration.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        quota_cnt_d  = quota_cnt_q;
        start_pkt_s  = 1'b0;
        next_beat_s  = 1'b0;
        drop_valid_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_d     = ST_SEND;
                    start_pkt_s = 1'b1;
                    idx_d       = {LW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (hs_s && !tlast_q) begin
                    next_beat_s = 1'b1;
                    idx_d       = idx_q + LEN_ONE;
                end else if (hs_s) begin
                    quota_cnt_d = quota_inc_s;
                    if (quota_hit_s) begin
                        state_d      = ST_DONE;
                        drop_valid_s = 1'b1;
                    end else if (!cfg_enable) begin
                        state_d      = ST_IDLE;
                        drop_valid_s = 1'b1;
                        quota_cnt_d  = {CW{1'b0}};
                    end else if (ifg_q != {IW{1'b0}}) begin
                        state_d      = ST_GAP;
                        drop_valid_s = 1'b1;
                        gap_d        = ifg_q - IFG_ONE;
                    end else begin
                        start_pkt_s = 1'b1;
                        idx_d       = {LW{1'b0}};
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_q != {IW{1'b0}}) begin
                    gap_d = gap_q - IFG_ONE;
                end else if (cfg_enable) begin
                    state_d     = ST_SEND;
                    start_pkt_s = 1'b1;
                    idx_d       = {LW{1'b0}};
                end else begin
                    state_d     = ST_IDLE;
                    quota_cnt_d = {CW{1'b0}};
                end
            end
            ST_DONE: begin
                if (!cfg_enable) begin
                    state_d     = ST_IDLE;
                    quota_cnt_d = {CW{1'b0}};
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                quota_cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // Beat source: live config at a packet start, shadow copy for the rest of the packet.
    always_comb begin
        b_len_s     = len_q;
        b_mode_s    = mode_q;
        b_pattern_s = pattern_q;
        b_src_s     = src_q;
        b_dst_s     = dst_q;
        b_seq_s     = seq_q;
        if (start_pkt_s) begin
            b_len_s     = eff_len_s;
            b_mode_s    = cfg_mode;
            b_pattern_s = cfg_pattern;
            b_src_s     = cfg_src_port;
            b_dst_s     = cfg_dst_port;
            b_seq_s     = stat_pkts_d;
        end else begin
            b_len_s = len_q;
        end
        b_idx_s      = idx_d;
        b_last_idx_s = (b_len_s - LEN_ONE) >> BW;
        b_last_s     = (b_idx_s == b_last_idx_s);
    end

    // Statistics next-state; a clear wins over a same-cycle increment.
    always_comb begin
        stat_pkts_d  = stat_pkts_q;
        stat_words_d = stat_words_q;
        if (stat_clear) begin
            stat_pkts_d  = {CW{1'b0}};
            stat_words_d = {CW{1'b0}};
        end else begin
            if (hs_s) begin
                stat_words_d = stat_words_q + CNT_ONE;
            end else begin
                stat_words_d = stat_words_q;
            end
            if (last_hs_s) begin
                stat_pkts_d = stat_pkts_q + CNT_ONE;
            end else begin
                stat_pkts_d = stat_pkts_q;
            end
        end
    end

    // FSM, counters and statistics registers.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q      <= ST_IDLE;
            idx_q        <= {LW{1'b0}};
            gap_q        <= {IW{1'b0}};
            quota_cnt_q  <= {CW{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stat_pkts_q  <= {CW{1'b0}};
            stat_words_q <= {CW{1'b0}};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            quota_cnt_q  <= quota_cnt_d;
            busy_q       <= (state_d == ST_SEND) || (state_d == ST_GAP);
            done_q       <= (state_d == ST_DONE);
            stat_pkts_q  <= stat_pkts_d;
            stat_words_q <= stat_words_d;
        end
    end

    // Shadow configuration, held for a packet and its following gap.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            len_q     <= {LW{1'b0}};
            ifg_q     <= {IW{1'b0}};
            quota_q   <= {CW{1'b0}};
            mode_q    <= 1'b0;
            pattern_q <= {DW{1'b0}};
            src_q     <= 8'h00;
            dst_q     <= 8'h00;
            seq_q     <= {CW{1'b0}};
        end else if (start_pkt_s) begin
            len_q     <= eff_len_s;
            ifg_q     <= cfg_ifg;
            quota_q   <= cfg_num_pkts;
            mode_q    <= cfg_mode;
            pattern_q <= cfg_pattern;
            src_q     <= cfg_src_port;
            dst_q     <= cfg_dst_port;
            seq_q     <= stat_pkts_d;
        end
    end

    // Stream output registers; a presented beat only changes after its handshake.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= {DW{1'b0}};
            tstrb_q  <= {SW{1'b0}};
            tuser_q  <= {UW{1'b0}};
        end else if (start_pkt_s || next_beat_s) begin
            tvalid_q <= 1'b1;
            tlast_q  <= b_last_s;
            tdata_q  <= beat_data(b_mode_s, b_pattern_s, b_seq_s, b_idx_s);
            tstrb_q  <= beat_strb(b_last_s, b_len_s[BW-1:0]);
            tuser_q  <= beat_user(start_pkt_s, b_len_s, b_src_s, b_dst_s);
        end else if (drop_valid_s) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= {DW{1'b0}};
            tstrb_q  <= {SW{1'b0}};
            tuser_q  <= {UW{1'b0}};
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tstrb  = tstrb_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign stat_tx_pkts  = stat_pkts_q;
    assign stat_tx_words = stat_words_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed and randomized bench for axis_pkt_gen; accepted beats are compared against a
// packet-level reference model built from lengths, modes and port fields.
module tb_axis_pkt_gen;

    logic          axi_aclk = 1'b0;
    logic          axi_areset;
    logic          cfg_enable;
    logic [15:0]   cfg_pkt_len;
    logic [15:0]   cfg_ifg;
    logic [31:0]   cfg_num_pkts;
    logic          cfg_mode;
    logic [63:0]   cfg_pattern;
    logic [7:0]    cfg_src_port, cfg_dst_port;
    logic          stat_clear;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tstrb;
    logic [127:0]  m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic          busy, done;
    logic [31:0]   stat_tx_pkts, stat_tx_words;

    axis_pkt_gen dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset), .cfg_enable(cfg_enable),
        .cfg_pkt_len(cfg_pkt_len), .cfg_ifg(cfg_ifg), .cfg_num_pkts(cfg_num_pkts),
        .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern), .cfg_src_port(cfg_src_port),
        .cfg_dst_port(cfg_dst_port), .stat_clear(stat_clear),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .stat_tx_pkts(stat_tx_pkts), .stat_tx_words(stat_tx_words)
    );

    always #5 axi_aclk = ~axi_aclk;

    int            vectors = 0;
    int            miscompares = 0;
    logic [255:0]  got_q[$];
    logic [255:0]  exp_q[$];
    int            gaps_q[$];
    logic [31:0]   exp_pkts = 32'd0;
    logic [31:0]   exp_words = 32'd0;
    bit            bp_rand = 1'b0;
    bit            stall_pend = 1'b0;
    bit            in_pkt = 1'b0;
    bit            last_flag = 1'b0;
    int            idle_run = 0;
    int            pkts_seen = 0;
    logic [255:0]  held, cur;

    function automatic logic [255:0] pack(input logic l, input logic [7:0] s,
                                          input logic [127:0] u, input logic [63:0] d);
        return {55'd0, l, s, u, d};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: n packets of the given configuration, numbered from the expected packet count.
    task automatic model_pkts(input int n, input int len, input bit mode, input logic [63:0] pat,
                              input logic [7:0] src, input logic [7:0] dst);
        int eff, nb, rem;
        logic [31:0] seq;
        logic [63:0] d;
        logic [7:0] s;
        logic [127:0] u;
        bit l;
        for (int p = 0; p < n; p++) begin
            eff = (len == 0) ? 64 : len;
            nb  = (eff + 7) / 8;
            rem = eff % 8;
            seq = exp_pkts;
            for (int i = 0; i < nb; i++) begin
                l = (i == nb - 1);
                d = mode ? {seq, 32'(i)} : pat;
                s = (l && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
                u = (i == 0) ? {96'd0, dst, src, 16'(eff)} : 128'd0;
                exp_q.push_back(pack(l, s, u, d));
                exp_words++;
            end
            exp_pkts++;
        end
    endtask

    // One clock: check stall stability, choose tready, record the beat that will be accepted.
    task automatic step();
        @(negedge axi_aclk);
        last_flag = 1'b0;
        cur = pack(m_axis_tlast, m_axis_tstrb, m_axis_tuser, m_axis_tdata);
        if (stall_pend) begin
            chk("hold_stable", {m_axis_tvalid, cur[254:0]}, {1'b1, held[254:0]});
        end
        m_axis_tready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_axis_tvalid) begin
            if (m_axis_tready) begin
                got_q.push_back(cur);
                if (!in_pkt) begin
                    gaps_q.push_back(idle_run);
                    in_pkt = 1'b1;
                end
                if (m_axis_tlast) begin
                    last_flag = 1'b1;
                    pkts_seen++;
                    in_pkt = 1'b0;
                    idle_run = 0;
                end
                stall_pend = 1'b0;
            end else begin
                stall_pend = 1'b1;
                held = cur;
            end
        end else begin
            idle_run++;
            stall_pend = 1'b0;
        end
    endtask

    task automatic configure(input int len, input int ifg, input int quota, input bit mode,
                             input logic [7:0] src, input logic [7:0] dst);
        cfg_pkt_len  = 16'(len);
        cfg_ifg      = 16'(ifg);
        cfg_num_pkts = 32'(quota);
        cfg_mode     = mode;
        cfg_pattern  = {$urandom, $urandom};
        cfg_src_port = src;
        cfg_dst_port = dst;
        got_q.delete();
        exp_q.delete();
        gaps_q.delete();
        pkts_seen = 0;
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        cfg_enable = 1'b1;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk("done_reached", {255'd0, done}, 256'd1);
    endtask

    task automatic stop_run();
        cfg_enable = 1'b0;
        step();
        step();
        chk("idle_busy", {255'd0, busy}, 256'd0);
        chk("idle_done", {255'd0, done}, 256'd0);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_beats"}, 256'(got_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic check_gaps(input string tag, input int g);
        for (int i = 1; i < gaps_q.size(); i++) begin
            chk($sformatf("%s_gap%0d", tag, i), 256'(gaps_q[i]), 256'(g));
        end
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_pkts"}, 256'(stat_tx_pkts), 256'(exp_pkts));
        chk({tag, "_words"}, 256'(stat_tx_words), 256'(exp_words));
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata, m_axis_tuser,
                  busy, done, stat_tx_pkts, stat_tx_words}, 256'd0);
    endtask

    initial begin
        int n, g, len;
        axi_areset = 1'b1;
        cfg_enable = 1'b0;
        stat_clear = 1'b0;
        m_axis_tready = 1'b0;
        configure(64, 0, 0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge axi_aclk);
        check_all_zero("reset_outputs");
        axi_areset = 1'b0;
        step();
        check_all_zero("after_release");

        // Basic 64-byte packets, quota 2, with first-beat latency.
        configure(64, 0, 2, 1'b0, 8'h01, 8'h04);
        model_pkts(2, 64, 1'b0, cfg_pattern, 8'h01, 8'h04);
        chk("pre_enable_valid", {255'd0, m_axis_tvalid}, 256'd0);
        cfg_enable = 1'b1;
        step();
        chk("first_latency", {255'd0, m_axis_tvalid}, 256'd1);
        run_until_done(200);
        compare_stream("basic");
        check_stats("basic");
        stop_run();

        // Partial last beat, then the zero-length default.
        configure(61, 0, 1, 1'b0, 8'h02, 8'h10);
        model_pkts(1, 61, 1'b0, cfg_pattern, 8'h02, 8'h10);
        run_until_done(200);
        compare_stream("len61");
        stop_run();
        configure(0, 0, 1, 1'b0, 8'h40, 8'h80);
        model_pkts(1, 0, 1'b0, cfg_pattern, 8'h40, 8'h80);
        run_until_done(200);
        compare_stream("len0");
        check_stats("len0");
        stop_run();

        // Single-beat packets back to back.
        configure(8, 0, 6, 1'b1, 8'h08, 8'h01);
        model_pkts(6, 8, 1'b1, cfg_pattern, 8'h08, 8'h01);
        run_until_done(200);
        compare_stream("single");
        check_gaps("single", 0);
        stop_run();

        // Statistics clear coinciding with the last-beat handshake.
        configure(16, 0, 1, 1'b0, 8'h01, 8'h01);
        model_pkts(1, 16, 1'b0, cfg_pattern, 8'h01, 8'h01);
        cfg_enable = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_flag && n < 200);
        chk("clr_last_seen", {255'd0, last_flag}, 256'd1);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        exp_pkts = 32'd0;
        exp_words = 32'd0;
        check_stats("clr");
        chk("clr_done", {255'd0, done}, 256'd1);
        compare_stream("clr");
        stop_run();

        // Randomized back-pressure with sequence payload and random length/gap.
        for (int r = 0; r < 3; r++) begin
            len = int'($urandom_range(1, 200));
            g = int'($urandom_range(0, 3));
            configure(len, g, 4, 1'b1, 8'(1 << r), 8'h20);
            model_pkts(4, len, 1'b1, cfg_pattern, 8'(1 << r), 8'h20);
            bp_rand = 1'b1;
            run_until_done(4000);
            bp_rand = 1'b0;
            compare_stream($sformatf("bp%0d", r));
            check_gaps($sformatf("bp%0d", r), g);
            check_stats($sformatf("bp%0d", r));
            stop_run();
        end

        // Continuous run with gap 5, then enable falls during the 11th packet.
        configure(24, 5, 0, 1'b1, 8'h04, 8'h02);
        model_pkts(11, 24, 1'b1, cfg_pattern, 8'h04, 8'h02);
        cfg_enable = 1'b1;
        n = 0;
        while (pkts_seen < 10 && n < 2000) begin
            step();
            n++;
        end
        do begin
            step();
            n++;
        end while (!m_axis_tvalid && n < 2000);
        chk("cont_first_beat11", {255'd0, m_axis_tvalid, m_axis_tlast}, 256'd2);
        cfg_enable = 1'b0;
        do begin
            step();
            n++;
        end while (!last_flag && n < 2000);
        step();
        chk("cont_busy_fell", {254'd0, busy, m_axis_tvalid}, 256'd0);
        compare_stream("cont");
        check_gaps("cont", 5);
        check_stats("cont");
        stop_run();

        // Reset asserted while the third beat is on the bus.
        configure(64, 0, 0, 1'b0, 8'h01, 8'h02);
        cfg_enable = 1'b1;
        n = 0;
        while (got_q.size() < 3 && n < 200) begin
            step();
            n++;
        end
        chk("rst_beat3_valid", {255'd0, m_axis_tvalid}, 256'd1);
        #2;
        axi_areset = 1'b1;
        #1;
        check_all_zero("rst_async");
        cfg_enable = 1'b0;
        stall_pend = 1'b0;
        in_pkt = 1'b0;
        step();
        axi_areset = 1'b0;
        repeat (4) step();
        chk("rst_no_resume", {254'd0, m_axis_tvalid, busy}, 256'd0);
        check_all_zero("rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

Parametrised AXI4-Stream packet generator for NetFPGA-10G data-path test projects, the next generation of the fixed two-beat transmitter. It emits packets of programmable byte length, inter-frame gap, destination/source port and payload mode, with full `m_axis_tready` back-pressure. It counts a programmable number of packets or runs continuously, and exports transmit statistics. It sits at the head of a loopback or measurement pipeline, with control ports driven from the project's register block.

## Interface
- `C_M_AXIS_DATA_WIDTH`, 64: stream data width in bits; a power of 2, minimum 32.
- `C_M_AXIS_TUSER_WIDTH`, 128: tuser width in bits; minimum 32.
- `C_LEN_WIDTH`, 16: width of the packet byte-length field.
- `C_IFG_WIDTH`, 16: width of the inter-frame gap count.
- `C_CNT_WIDTH`, 32: width of the packet quota and statistics counters.

Ports:
- `axi_aclk` in 1: the only clock; all logic is on its rising edge.
- `axi_areset` in 1: asynchronous, active-high reset.
- `cfg_enable` in 1: run request; level-sensitive.
- `cfg_pkt_len` in C_LEN_WIDTH: packet length in bytes; 0 is treated as 64.
- `cfg_ifg` in C_IFG_WIDTH: idle cycles between packets.
- `cfg_num_pkts` in C_CNT_WIDTH: packet quota; 0 means continuous.
- `cfg_mode` in 1: payload mode; 0 = fixed pattern, 1 = sequence/index.
- `cfg_pattern` in C_M_AXIS_DATA_WIDTH: fixed payload word.
- `cfg_src_port`, `cfg_dst_port` in 8: the NetFPGA port one-hot fields.
- `stat_clear` in 1: synchronous clear of the statistics counters.
- `m_axis_tdata` out C_M_AXIS_DATA_WIDTH: stream data.
- `m_axis_tstrb` out C_M_AXIS_DATA_WIDTH/8: stream byte strobes.
- `m_axis_tuser` out C_M_AXIS_TUSER_WIDTH: stream sideband.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tlast` out 1: last beat of a packet.
- `m_axis_tready` in 1: downstream ready.
- `busy` out 1: high in any state other than IDLE and DONE.
- `done` out 1: high in DONE.
- `stat_tx_pkts` out C_CNT_WIDTH: packets completed.
- `stat_tx_words` out C_CNT_WIDTH: beats accepted.

## Operation
- B = C_M_AXIS_DATA_WIDTH/8.
- Config sampling: all `cfg_*` fields are sampled into shadow registers on the IDLE→SEND and GAP→SEND transitions. The shadow registers stay constant for the whole packet and its following gap.
- Packet size: words W = ceil(L/B), where L is the effective byte length. Last-beat strobe: if L mod B = 0, all ones; otherwise the low (L mod B) bits are set.
- tuser: nonzero on the first beat only; zero on every other beat.
  - [15:0] = L, truncated or zero-extended to 16 bits.
  - [23:16] = src port.
  - [31:24] = dst port.
  - Upper bits are 0.
- tdata, mode 0: `cfg_pattern` on every beat.
- tdata, mode 1: upper half = packet sequence number (the `stat_tx_pkts` value at packet start); lower half = word index starting at 0. Each field is truncated to DW/2 bits.
- State machine: IDLE, SEND, GAP, DONE.
  - IDLE→SEND when `cfg_enable` is 1.
  - SEND: a beat completes on `tvalid & tready`. After the beat with `tlast` completes:
    - go to DONE if the quota is reached;
    - otherwise go to GAP if the gap is greater than 0;
    - otherwise go to SEND, starting the next packet.
  - GAP: counts `cfg_ifg` cycles with `tvalid` low, then goes to SEND. If `cfg_enable` is 0 at the end of the gap, it goes to IDLE instead.
  - DONE: held until `cfg_enable` is 0, then goes to IDLE. The quota counter is cleared on entry to IDLE.
- `cfg_enable` falling mid-packet: the current packet completes, with no truncation. The FSM then goes to IDLE, not GAP, and skips the gap.
- The SEND→SEND back-to-back transition (gap 0) re-checks `cfg_enable`; if it is low, the FSM goes to IDLE.
- `stat_clear` has priority over an increment in the same cycle. The counters wrap at 2^C_CNT_WIDTH. The quota uses its own counter and is unaffected by `stat_clear`.

## Timing
- All stream outputs are registered.
- Latency: first `tvalid` is 1 cycle after the cycle in which the FSM is in IDLE and sees `cfg_enable` = 1.
- AXI rule: once `tvalid` is 1, tdata, tstrb, tuser, tlast and tvalid hold stable until `tready`. `tvalid` never depends combinationally on `tready`.
- Throughput: one beat per cycle while `tready` = 1.
- With gap 0, the next packet's first beat is presented in the cycle after the last-beat handshake; there is no bubble.
- With gap G, there are exactly G cycles with `tvalid` = 0 between the last-beat handshake and the next first beat.
- Single-beat packets (L ≤ B): first and last beat coincide; tuser and `tlast` are both asserted.
- Statistics: `stat_tx_words` increments on each handshake. `stat_tx_pkts` increments on the handshake of the last beat. Both are visible the next cycle.
- Reset values: every output is 0, the state is IDLE, and all counters are 0.
- `axi_areset` asserted mid-packet drops `tvalid` immediately (asynchronously). No packet resumes after reset release.

## Test plan
- Basic length: L=64, gap 0, quota 2, `tready`=1 → 16 beats; `tlast` on beats 8 and 16; tuser on beats 1 and 9 = 0x...0000_0040 | ports; then `done`; `stat_tx_pkts`=2, `stat_tx_words`=16.
- Partial last beat: L=61, B=8 → 8 beats; last-beat tstrb = 0x1F; tuser[15:0] = 61. Also L=0 → 8 beats with tuser[15:0] = 64.
- Back-pressure: mode 1, `tready` toggling in a pseudo-random pattern → every accepted beat carries {seq, index} in order; outputs are stable during stalls; no beat is lost or duplicated.
- Gap and continuous run: gap 5, quota 0, 10 packets → exactly 5 `tvalid`-low cycles between packets. Deassert `cfg_enable` mid-packet → the packet finishes, then IDLE; `busy` falls with no gap.
- Single-beat packets: L=8, gap 0 → every beat has both `tlast` and tuser set; stream runs at 1 packet per cycle.
- Reset and clear: assert `axi_areset` on beat 3 → all outputs 0 within the reset cycle, state is IDLE. Assert `stat_clear` together with a last-beat handshake → counters read 0 the next cycle.
